// File: rtl/window_pkg.sv
// Shared types and helpers for the NxN window buffer.
//   op_t    : command opcodes carried on cmd_op
//   state_t : controller states
//   idx()   : flattened element index of (row, col) in a win x win window
package window_pkg;

  typedef enum logic [1:0] {
    OP_LOAD        = 2'd0,
    OP_SHIFT_RIGHT = 2'd1,
    OP_SHIFT_DOWN  = 2'd2,
    OP_SHIFT_LEFT  = 2'd3
  } op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  function automatic int unsigned idx(input int unsigned row,
                                      input int unsigned col,
                                      input int unsigned win);
    return row * win + col;
  endfunction

endpackage

// File: rtl/window_addr_gen.sv
// Combinational write-address generator for the window buffer.
//   i_op    : op currently being filled
//   i_count : pixels already accepted in this op
//   o_k     : flattened element index the next accepted pixel is written to
module window_addr_gen
  import window_pkg::*;
#(
  parameter int WIN   = 3,
  parameter int CNT_W = $clog2(WIN * WIN + 1)
) (
  input  op_t              i_op,
  input  logic [CNT_W-1:0] i_count,
  output logic [CNT_W-1:0] o_k
);

  always_comb begin
    o_k = '0;
    case (i_op)
      OP_LOAD:        o_k = i_count;
      OP_SHIFT_RIGHT: o_k = CNT_W'(idx(32'(i_count), WIN - 1, WIN));
      OP_SHIFT_DOWN:  o_k = CNT_W'(idx(WIN - 1, 32'(i_count), WIN));
      OP_SHIFT_LEFT:  o_k = CNT_W'(idx(32'(i_count), 0, WIN));
      default:        o_k = i_count;
    endcase
  end

endmodule

// File: rtl/window_buffer_nxn.sv
// WIN x WIN pixel window buffer filled from a valid/ready pixel stream.
// A command either reloads the whole window in raster order or slides it by
// one step (right, down, left) and streams in only the new edge line.
//   clk, rst             : clock, synchronous active-high reset
//   cmd_valid/cmd_ready  : command handshake (ready only in IDLE)
//   cmd_op               : 0=LOAD 1=SHIFT_RIGHT 2=SHIFT_DOWN 3=SHIFT_LEFT
//   pix_valid/pix_ready  : pixel handshake (ready only in FILL)
//   pix_data             : incoming pixel
//   window               : flattened window, element row*WIN+col
//   win_valid            : window complete and stable
//   done                 : one-cycle pulse on op completion
//   error                : one-cycle pulse on a shift with no valid window
//   pix_count            : pixels accepted in the current op
module window_buffer_nxn
  import window_pkg::*;
#(
  parameter int PIXEL_W = 8,
  parameter int WIN     = 3,
  parameter int CNT_W   = $clog2(WIN * WIN + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  input  logic [PIXEL_W-1:0]         pix_data,
  output logic [WIN*WIN*PIXEL_W-1:0] window,
  output logic                       win_valid,
  output logic                       done,
  output logic                       error,
  output logic [CNT_W-1:0]           pix_count
);

  localparam int NPIX = WIN * WIN;

  state_t             r_state;
  op_t                r_op;
  logic [CNT_W-1:0]   r_count;
  logic [PIXEL_W-1:0] r_win [NPIX];
  logic               r_win_valid;
  logic               r_done;
  logic               r_error;

  op_t                w_cmd_op;
  logic [CNT_W-1:0]   w_k;
  logic [CNT_W-1:0]   w_target;
  logic               w_last;

  assign w_cmd_op = op_t'(cmd_op);
  assign w_target = (r_op == OP_LOAD) ? CNT_W'(NPIX) : CNT_W'(WIN);
  assign w_last   = (r_count == w_target - CNT_W'(1));

  window_addr_gen #(
    .WIN   (WIN),
    .CNT_W (CNT_W)
  ) u_addr_gen (
    .i_op    (r_op),
    .i_count (r_count),
    .o_k     (w_k)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_LOAD;
      r_count     <= '0;
      r_win_valid <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      for (int unsigned k = 0; k < NPIX; k++) r_win[CNT_W'(k)] <= '0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (w_cmd_op == OP_LOAD) begin
              r_op        <= OP_LOAD;
              r_state     <= ST_FILL;
              r_win_valid <= 1'b0;
              r_count     <= '0;
            end else if (!r_win_valid) begin
              r_error <= 1'b1;
            end else begin
              r_op        <= w_cmd_op;
              r_state     <= ST_FILL;
              r_win_valid <= 1'b0;
              r_count     <= '0;
              // Shift on the accept edge; the vacated edge line is left
              // untouched and gets overwritten by the streamed pixels.
              for (int unsigned r = 0; r < WIN; r++) begin
                for (int unsigned c = 0; c < WIN; c++) begin
                  case (w_cmd_op)
                    OP_SHIFT_RIGHT:
                      if (c < WIN - 1)
                        r_win[CNT_W'(idx(r, c, WIN))] <= r_win[CNT_W'(idx(r, c + 1, WIN))];
                    OP_SHIFT_DOWN:
                      if (r < WIN - 1)
                        r_win[CNT_W'(idx(r, c, WIN))] <= r_win[CNT_W'(idx(r + 1, c, WIN))];
                    OP_SHIFT_LEFT:
                      if (c > 0)
                        r_win[CNT_W'(idx(r, c, WIN))] <= r_win[CNT_W'(idx(r, c - 1, WIN))];
                    default: ;
                  endcase
                end
              end
            end
          end
        end
        ST_FILL: begin
          if (pix_valid) begin
            r_win[w_k] <= pix_data;
            if (w_last) begin
              r_state     <= ST_IDLE;
              r_done      <= 1'b1;
              r_win_valid <= 1'b1;
              r_count     <= '0;
            end else begin
              r_count <= r_count + CNT_W'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    window = '0;
    for (int unsigned k = 0; k < NPIX; k++)
      window[k*PIXEL_W +: PIXEL_W] = r_win[CNT_W'(k)];
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign pix_ready = (r_state == ST_FILL);
  assign win_valid = r_win_valid;
  assign done      = r_done;
  assign error     = r_error;
  assign pix_count = r_count;

endmodule

// File: tb/tb_window_buffer_nxn.sv
module tb_window_buffer_nxn;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIN=3, PIXEL_W=8 instance
  logic        rst3 = 1'b1, cv3 = 1'b0, pv3 = 1'b0;
  logic [1:0]  op3 = 2'd0;
  logic [7:0]  pd3 = '0;
  logic        crdy3, prdy3, wv3, done3, err3;
  logic [71:0] win3;
  logic [3:0]  cnt3;

  // WIN=5, PIXEL_W=10 instance
  logic         rst5 = 1'b1, cv5 = 1'b0, pv5 = 1'b0;
  logic [1:0]   op5 = 2'd0;
  logic [9:0]   pd5 = '0;
  logic         crdy5, prdy5, wv5, done5, err5;
  logic [249:0] win5;
  logic [4:0]   cnt5;

  window_buffer_nxn #(.PIXEL_W(8), .WIN(3)) u_dut3 (
    .clk(clk), .rst(rst3), .cmd_valid(cv3), .cmd_ready(crdy3), .cmd_op(op3),
    .pix_valid(pv3), .pix_ready(prdy3), .pix_data(pd3), .window(win3),
    .win_valid(wv3), .done(done3), .error(err3), .pix_count(cnt3));

  window_buffer_nxn #(.PIXEL_W(10), .WIN(5)) u_dut5 (
    .clk(clk), .rst(rst5), .cmd_valid(cv5), .cmd_ready(crdy5), .cmd_op(op5),
    .pix_valid(pv5), .pix_ready(prdy5), .pix_data(pd5), .window(win5),
    .win_valid(wv5), .done(done5), .error(err5), .pix_count(cnt5));

  int checks = 0;
  int failures = 0;

  // Reference model of the 3x3 window: m3[row][col], plus its valid flag.
  logic [7:0] m3 [3][3];
  bit         mv3;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] exp3();
    logic [255:0] e = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        e[(r*3+c)*8 +: 8] = m3[r][c];
    return e;
  endfunction

  task automatic model_clear3();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) m3[r][c] = '0;
    mv3 = 0;
  endtask

  task automatic model_shift3(input int op);
    logic [7:0] t [3][3];
    t = m3;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        if (op == 1 && c < 2) m3[r][c] = t[r][c+1];
        if (op == 2 && r < 2) m3[r][c] = t[r+1][c];
        if (op == 3 && c > 0) m3[r][c] = t[r][c-1];
      end
  endtask

  task automatic reset3();
    rst3 = 1'b1; cv3 = 1'b0; pv3 = 1'b0;
    @(posedge clk); #1;
    rst3 = 1'b0;
    model_clear3();
    chk("rst_window", win3, exp3());
    chk("rst_win_valid", wv3, 0);
    chk("rst_cmd_ready", crdy3, 1);
    chk("rst_pix_ready", prdy3, 0);
    chk("rst_pix_count", cnt3, 0);
    chk("rst_done", done3, 0);
  endtask

  // Issue one command and, when legal, stream its pixels (optionally with gaps).
  task automatic do_op3(input int op, input logic [7:0] vals[$], input bit gaps);
    int n;
    int r, c;
    chk("pre_cmd_ready", crdy3, 1);
    cv3 = 1'b1; op3 = 2'(op);
    @(posedge clk); #1;
    cv3 = 1'b0;
    chk("done_one_cycle", done3, 0);
    if (op != 0 && !mv3) begin
      chk("err_pulse", err3, 1);
      chk("err_cmd_ready", crdy3, 1);
      chk("err_pix_ready", prdy3, 0);
      chk("err_win_valid", wv3, 0);
      chk("err_window", win3, exp3());
      @(posedge clk); #1;
      chk("err_cleared", err3, 0);
      return;
    end
    chk("op_no_err", err3, 0);
    chk("op_win_valid_low", wv3, 0);
    chk("op_pix_ready", prdy3, 1);
    chk("op_cmd_ready_low", crdy3, 0);
    if (op != 0) model_shift3(op);
    mv3 = 0;
    n = (op == 0) ? 9 : 3;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          pv3 = 1'b0;
          @(posedge clk); #1;
          chk("stall_pix_count", cnt3, i);
        end
      end
      chk("pix_count", cnt3, i);
      chk("mid_done_low", done3, 0);
      pv3 = 1'b1; pd3 = vals[i];
      @(posedge clk); #1;
      pv3 = 1'b0;
      case (op)
        0: begin r = i / 3; c = i % 3; end
        1: begin r = i; c = 2; end
        2: begin r = 2; c = i; end
        default: begin r = i; c = 0; end
      endcase
      m3[r][c] = vals[i];
    end
    mv3 = 1;
    chk("done_pulse", done3, 1);
    chk("end_win_valid", wv3, 1);
    chk("end_pix_count", cnt3, 0);
    chk("end_cmd_ready", crdy3, 1);
    chk("end_window", win3, exp3());
  endtask

  initial begin
    logic [7:0]   q[$];
    logic [255:0] lit;
    logic [255:0] e5;

    // Test 1: reset and LOAD 0..8 back-to-back
    reset3();
    q = {};
    for (int i = 0; i < 9; i++) q.push_back(8'(i));
    do_op3(0, q, 0);
    lit = '0;
    for (int k = 0; k < 9; k++) lit[k*8 +: 8] = 8'(k);
    chk("load_literal", win3, lit);

    // pix_valid in IDLE is ignored
    pv3 = 1'b1; pd3 = 8'hAA;
    @(posedge clk); #1;
    pv3 = 1'b0;
    chk("idle_pix_ignored", win3, exp3());
    chk("idle_pix_count", cnt3, 0);
    chk("idle_done_cleared", done3, 0);

    // Test 2/3: SHIFT_RIGHT then SHIFT_DOWN
    do_op3(1, '{8'd9, 8'd10, 8'd11}, 0);
    lit = {184'd0, 8'd11, 8'd8, 8'd7, 8'd10, 8'd5, 8'd4, 8'd9, 8'd2, 8'd1};
    chk("right_literal", win3, lit);
    do_op3(2, '{8'd20, 8'd21, 8'd22}, 0);
    lit = {184'd0, 8'd22, 8'd21, 8'd20, 8'd11, 8'd8, 8'd7, 8'd10, 8'd5, 8'd4};
    chk("down_literal", win3, lit);

    // SHIFT_LEFT from a fresh raster load
    reset3();
    do_op3(0, q, 0);
    do_op3(3, '{8'd30, 8'd31, 8'd32}, 0);
    lit = {184'd0, 8'd7, 8'd6, 8'd32, 8'd4, 8'd3, 8'd31, 8'd1, 8'd0, 8'd30};
    chk("left_literal", win3, lit);

    // Test 4: shift without a valid window
    reset3();
    do_op3(1, '{8'd1, 8'd2, 8'd3}, 0);
    chk("err_window_zero", win3, 0);

    // Test 6: reset in the middle of a LOAD
    cv3 = 1'b1; op3 = 2'd0;
    @(posedge clk); #1;
    cv3 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pv3 = 1'b1; pd3 = 8'(50 + i);
      @(posedge clk); #1;
    end
    pv3 = 1'b0;
    chk("midop_pix_count", cnt3, 4);
    reset3();
    do_op3(0, '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9}, 1);

    // Randomised op sequence against the model (back-to-back commands)
    reset3();
    for (int it = 0; it < 30; it++) begin
      int op;
      op = $urandom_range(0, 3);
      q = {};
      for (int i = 0; i < 9; i++) q.push_back(8'($urandom));
      do_op3(op, q, 1);
    end

    // Test 5: WIN=5, PIXEL_W=10 with pix_valid toggling
    rst5 = 1'b1;
    @(posedge clk); #1;
    rst5 = 1'b0;
    chk("w5_rst_window", win5, 0);
    chk("w5_rst_cmd_ready", crdy5, 1);
    cv5 = 1'b1; op5 = 2'd0;
    @(posedge clk); #1;
    cv5 = 1'b0;
    chk("w5_pix_ready", prdy5, 1);
    for (int i = 0; i < 25; i++) begin
      pv5 = 1'b0;
      @(posedge clk); #1;
      chk("w5_gap_pix_count", cnt5, i);
      chk("w5_gap_done_low", done5, 0);
      pv5 = 1'b1; pd5 = 10'(100 + i);
      @(posedge clk); #1;
    end
    pv5 = 1'b0;
    chk("w5_done", done5, 1);
    chk("w5_win_valid", wv5, 1);
    chk("w5_pix_count_end", cnt5, 0);
    chk("w5_elem24", win5[24*10 +: 10], 124);
    e5 = '0;
    for (int k = 0; k < 25; k++) e5[k*10 +: 10] = 10'(100 + k);
    chk("w5_window", win5, e5);
    @(posedge clk); #1;
    chk("w5_done_cleared", done5, 0);
    chk("w5_err_never", err5, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
